// File: rtl/demux_1to4_buf_if.sv
// Bus bundle for the buffered 1-to-4 demultiplexer: one valid/ready input stream,
// four valid/ready output lanes, and an occupancy readout.
interface demux_1to4_buf_if #(
   parameter int DATAWIDTH = 32
);
   logic                     in_valid_i;
   logic                     in_ready_o;
   logic [1:0]               in_sel_i;
   logic [DATAWIDTH-1:0]     in_data_i;
   logic [3:0]               out_valid_o;
   logic [3:0]               out_ready_i;
   logic [4*DATAWIDTH-1:0]   out_data_o;
   logic [1:0]               count_o;

   // Producer / consumer side (testbench or surrounding logic).
   modport master (
      output in_valid_i, in_sel_i, in_data_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o, count_o
   );

   // The demultiplexer itself.
   modport slave (
      input  in_valid_i, in_sel_i, in_data_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o, count_o
   );
endinterface

// File: rtl/demux_1to4_buf.sv
// Buffered 1-to-4 demultiplexer: a 2-entry FIFO of {sel, data} whose head is steered
// onto exactly one of four output lanes.
module demux_1to4_buf #(
   parameter int DATAWIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   demux_1to4_buf_if.slave  bus
);
   // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
   // valid never depends on ready, and a raised valid holds with stable data until taken.

   logic [1:0]           sel_q  [2];
   logic [DATAWIDTH-1:0] data_q [2];
   logic                 wptr_q;
   logic                 rptr_q;
   logic [1:0]           count_q;

   logic                 push;
   logic                 pop;
   logic                 not_empty;
   logic [1:0]           head_sel;
   logic [DATAWIDTH-1:0] head_data;

   assign not_empty = (count_q != 2'd0);
   assign head_sel  = sel_q[rptr_q];
   assign head_data = data_q[rptr_q];

   // Ready is a function of occupancy only, so no path exists from out_ready_i.
   assign bus.in_ready_o = (count_q != 2'd2);
   assign bus.count_o    = count_q;

   assign push = bus.in_valid_i && bus.in_ready_o;
   assign pop  = not_empty && bus.out_ready_i[head_sel];

   always_comb begin
      bus.out_valid_o = 4'b0000;
      bus.out_data_o  = '0;
      if (not_empty) begin
         bus.out_valid_o[head_sel] = 1'b1;
         bus.out_data_o[head_sel*DATAWIDTH +: DATAWIDTH] = head_data;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sel_q[0]  <= 2'd0;
         sel_q[1]  <= 2'd0;
         data_q[0] <= '0;
         data_q[1] <= '0;
         wptr_q    <= 1'b0;
         rptr_q    <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         if (push) begin
            sel_q[wptr_q]  <= bus.in_sel_i;
            data_q[wptr_q] <= bus.in_data_i;
            wptr_q         <= ~wptr_q;
         end
         if (pop) begin
            rptr_q <= ~rptr_q;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: tb/tb_demux_1to4_buf.sv
// Directed self-checking bench for demux_1to4_buf: reset, routing, backpressure,
// head-of-line blocking, streaming with pointer wrap, and reset mid-operation.
module tb_demux_1to4_buf;
   localparam int DW = 32;

   logic clk_i;
   logic rst_ni;
   int   checks;
   int   errors;

   demux_1to4_buf_if #(.DATAWIDTH(DW)) bus ();

   demux_1to4_buf #(.DATAWIDTH(DW)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus.slave)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [4*DW-1:0] obs, input logic [4*DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [3:0] vld, input logic [4*DW-1:0] dat,
                              input logic [1:0] cnt, input logic rdy);
      check({tag, "_valid"}, {124'd0, bus.out_valid_o}, {124'd0, vld});
      check({tag, "_data"},  bus.out_data_o, dat);
      check({tag, "_count"}, {126'd0, bus.count_o}, {126'd0, cnt});
      check({tag, "_ready"}, {127'd0, bus.in_ready_o}, {127'd0, rdy});
   endtask

   function automatic logic [4*DW-1:0] lane(input int n, input logic [DW-1:0] d);
      logic [4*DW-1:0] v;
      v = '0;
      v[n*DW +: DW] = d;
      return v;
   endfunction

   task automatic drive(input logic v, input logic [1:0] s, input logic [DW-1:0] d);
      bus.in_valid_i = v;
      bus.in_sel_i   = s;
      bus.in_data_i  = d;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_ni = 1'b0;
      bus.out_ready_i = 4'h0;
      drive(1'b0, 2'd0, '0);

      // 1: reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
         bus.out_ready_i = 4'($urandom_range(0, 15));
         tick();
         check_state("reset", 4'b0000, '0, 2'd0, 1'b1);
      end
      drive(1'b0, 2'd0, '0);
      bus.out_ready_i = 4'hF;
      rst_ni = 1'b1;
      tick();
      tick();
      check_state("idle", 4'b0000, '0, 2'd0, 1'b1);

      // 2: single route to lane C
      drive(1'b1, 2'd2, 32'hDEADBEEF);
      tick();
      drive(1'b0, 2'd0, '0);
      check_state("route", 4'b0100, lane(2, 32'hDEADBEEF), 2'd1, 1'b1);
      tick();
      check_state("route_pop", 4'b0000, '0, 2'd0, 1'b1);

      // 3: backpressure and full
      bus.out_ready_i = 4'h0;
      drive(1'b1, 2'd1, 32'hA1);
      tick();
      drive(1'b1, 2'd3, 32'hA3);
      tick();
      drive(1'b0, 2'd0, '0);
      check_state("full", 4'b0010, lane(1, 32'hA1), 2'd2, 1'b0);
      drive(1'b1, 2'd0, 32'h55);
      tick();
      drive(1'b0, 2'd0, '0);
      check_state("full_hold", 4'b0010, lane(1, 32'hA1), 2'd2, 1'b0);
      bus.out_ready_i = 4'b0010;
      tick();
      bus.out_ready_i = 4'h0;
      check_state("pop_b", 4'b1000, lane(3, 32'hA3), 2'd1, 1'b1);
      bus.out_ready_i = 4'b0111;
      tick();
      check_state("d_blocked", 4'b1000, lane(3, 32'hA3), 2'd1, 1'b1);
      bus.out_ready_i = 4'hF;
      tick();
      check_state("drain", 4'b0000, '0, 2'd0, 1'b1);

      // 4: head-of-line blocking
      bus.out_ready_i = 4'b0010;
      drive(1'b1, 2'd0, 32'h40);
      tick();
      drive(1'b1, 2'd1, 32'h41);
      tick();
      drive(1'b0, 2'd0, '0);
      check_state("hol", 4'b0001, lane(0, 32'h40), 2'd2, 1'b0);
      tick();
      check_state("hol_hold", 4'b0001, lane(0, 32'h40), 2'd2, 1'b0);
      bus.out_ready_i = 4'b0011;
      tick();
      check_state("hol_a", 4'b0010, lane(1, 32'h41), 2'd1, 1'b1);
      tick();
      check_state("hol_b", 4'b0000, '0, 2'd0, 1'b1);

      // 5: back-to-back streaming across all lanes with pointer wrap
      bus.out_ready_i = 4'hF;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 2'(i % 4), 32'(i));
         tick();
         check_state($sformatf("stream%0d", i), 4'(1 << (i % 4)), lane(i % 4, 32'(i)), 2'd1, 1'b1);
      end
      drive(1'b0, 2'd0, '0);
      tick();
      check_state("stream_end", 4'b0000, '0, 2'd0, 1'b1);

      // 6: reset while full
      bus.out_ready_i = 4'h0;
      drive(1'b1, 2'd1, 32'hA1);
      tick();
      drive(1'b1, 2'd2, 32'hA2);
      tick();
      drive(1'b0, 2'd0, '0);
      check_state("pre_rst", 4'b0010, lane(1, 32'hA1), 2'd2, 1'b0);
      #2;
      rst_ni = 1'b0;
      #1;
      check_state("async_rst", 4'b0000, '0, 2'd0, 1'b1);
      tick();
      rst_ni = 1'b1;
      bus.out_ready_i = 4'hF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_state("post_rst", 4'b0000, '0, 2'd0, 1'b1);
      end
      drive(1'b1, 2'd0, 32'h77);
      tick();
      drive(1'b0, 2'd0, '0);
      check_state("post_rst_push", 4'b0001, lane(0, 32'h77), 2'd1, 1'b1);
      tick();
      check_state("post_rst_done", 4'b0000, '0, 2'd0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
